// File: rtl/fnc_uart_pkg.sv
// rtl/fnc_uart_pkg.sv - shared state encoding, parity codes and frame-width helper for the UART transmitter
package fnc_uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_e;

   localparam logic [1:0] PAR_NONE  = 2'b00;
   localparam logic [1:0] PAR_EVEN  = 2'b01;
   localparam logic [1:0] PAR_ODD   = 2'b10;
   localparam logic [3:0] DBITS_MIN = 4'd5;

   // Requested data-bit count folded into the supported window [DBITS_MIN, max_bits].
   function automatic logic [3:0] clamp_dbits(input logic [3:0] req, input logic [3:0] max_bits);
      if (req < DBITS_MIN) return DBITS_MIN;
      if (req > max_bits) return max_bits;
      return req;
   endfunction

endpackage

// File: rtl/fnc_uart_fifo.sv
// rtl/fnc_uart_fifo.sv - synchronous FIFO with registered occupancy and flush
module fnc_uart_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       full,
   output logic                       empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      cnt_q;
   logic             do_push, do_pop;

   assign full    = (cnt_q == (AW+1)'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign level   = cnt_q;
   assign dout    = mem_q[rd_ptr_q];
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
            2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/fnc_uart_txp.sv
// rtl/fnc_uart_txp.sv - FIFO-buffered UART transmitter with runtime frame format
module fnc_uart_txp
   import fnc_uart_pkg::*;
#(
   parameter int DW         = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int OSR        = 16,
   parameter int CNT_W      = 32
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           uart_en,
   input  logic [CNT_W-1:0]               refclk_st,
   input  logic [3:0]                     cfg_dbits,
   input  logic [1:0]                     cfg_parity,
   input  logic                           cfg_stop2,
   input  logic                           wr_en,
   input  logic [DW-1:0]                  wr_data,
   output logic                           fifo_full,
   output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
   output logic                           ovf_err,
   input  logic                           err_clr,
   output logic                           tx_busy,
   output logic                           txd
);
   localparam int             OSW       = (OSR > 1) ? $clog2(OSR) : 1;
   localparam logic [3:0]     DBITS_MAX = 4'(DW);
   localparam logic [OSW-1:0] OS_LAST   = OSW'(OSR - 1);

   tx_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [OSW-1:0]   os_q, os_d;
   logic [3:0]       bcnt_q, bcnt_d;
   logic [DW-1:0]    shift_q, shift_d;
   logic             par_bit_q, par_bit_d;
   logic             par_en_q, par_en_d;
   logic             stop2_q, stop2_d;
   logic [3:0]       dbits_q, dbits_d;
   logic             txd_q, txd_d;
   logic             ovf_q;

   logic             fifo_pop, fifo_empty, fifo_flush;
   logic [DW-1:0]    fifo_dout;
   logic             tick, bit_end, start_frame;
   logic [3:0]       new_dbits;
   logic [DW-1:0]    new_word;

   assign fifo_flush = !uart_en;

   fnc_uart_fifo #(
      .WIDTH (DW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (fifo_flush),
      .push  (wr_en),
      .pop   (fifo_pop),
      .din   (wr_data),
      .dout  (fifo_dout),
      .level (fifo_level),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign tick    = (cnt_q == '0);
   assign bit_end = tick && (os_q == OS_LAST);

   // Head-of-FIFO word with bits beyond the selected width cleared, ready to latch.
   always_comb begin
      new_dbits = clamp_dbits(cfg_dbits, DBITS_MAX);
      new_word  = '0;
      for (int i = 0; i < DW; i++) begin
         if (4'(i) < new_dbits) new_word[i] = fifo_dout[i];
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      os_d        = os_q;
      bcnt_d      = bcnt_q;
      shift_d     = shift_q;
      par_bit_d   = par_bit_q;
      par_en_d    = par_en_q;
      stop2_d     = stop2_q;
      dbits_d     = dbits_q;
      txd_d       = txd_q;
      fifo_pop    = 1'b0;
      start_frame = 1'b0;

      if (state_q == ST_IDLE) begin
         cnt_d = refclk_st;
         os_d  = '0;
      end else if (tick) begin
         cnt_d = refclk_st;
         os_d  = bit_end ? '0 : os_q + OSW'(1);
      end else begin
         cnt_d = cnt_q - CNT_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
            txd_d = 1'b1;
            if (!fifo_empty) start_frame = 1'b1;
         end
         ST_START: begin
            if (bit_end) begin
               state_d = ST_DATA;
               txd_d   = shift_q[0];
               shift_d = shift_q >> 1;
               bcnt_d  = 4'd1;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               if (bcnt_q == dbits_q) begin
                  state_d = par_en_q ? ST_PARITY : ST_STOP;
                  txd_d   = par_en_q ? par_bit_q : 1'b1;
                  bcnt_d  = 4'd1;
               end else begin
                  txd_d   = shift_q[0];
                  shift_d = shift_q >> 1;
                  bcnt_d  = bcnt_q + 4'd1;
               end
            end
         end
         ST_PARITY: begin
            if (bit_end) begin
               state_d = ST_STOP;
               txd_d   = 1'b1;
               bcnt_d  = 4'd1;
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               if (!stop2_q || bcnt_q == 4'd2) begin
                  state_d = ST_IDLE;
                  txd_d   = 1'b1;
                  if (!fifo_empty) start_frame = 1'b1;
               end else begin
                  bcnt_d = 4'd2;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            txd_d   = 1'b1;
         end
      endcase

      // Frame start restarts bit timing so the start bit is a full bit time.
      if (start_frame) begin
         fifo_pop  = 1'b1;
         state_d   = ST_START;
         txd_d     = 1'b0;
         cnt_d     = refclk_st;
         os_d      = '0;
         bcnt_d    = '0;
         shift_d   = new_word;
         dbits_d   = new_dbits;
         par_en_d  = (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
         par_bit_d = (^new_word) ^ (cfg_parity == PAR_ODD);
         stop2_d   = cfg_stop2;
      end

      if (!uart_en) begin
         fifo_pop = 1'b0;
         state_d  = ST_IDLE;
         txd_d    = 1'b1;
         cnt_d    = refclk_st;
         os_d     = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         os_q      <= '0;
         bcnt_q    <= '0;
         shift_q   <= '0;
         par_bit_q <= 1'b0;
         par_en_q  <= 1'b0;
         stop2_q   <= 1'b0;
         dbits_q   <= DBITS_MIN;
         txd_q     <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         os_q      <= os_d;
         bcnt_q    <= bcnt_d;
         shift_q   <= shift_d;
         par_bit_q <= par_bit_d;
         par_en_q  <= par_en_d;
         stop2_q   <= stop2_d;
         dbits_q   <= dbits_d;
         txd_q     <= txd_d;
      end
   end

   // A write against a full FIFO outranks a same-cycle clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (wr_en && fifo_full) begin
         ovf_q <= 1'b1;
      end else if (err_clr) begin
         ovf_q <= 1'b0;
      end
   end

   assign ovf_err = ovf_q;
   assign tx_busy = (state_q != ST_IDLE);
   assign txd     = txd_q;

endmodule

// File: tb/tb_fnc_uart_txp.sv
// tb/tb_fnc_uart_txp.sv - self-checking bench for the FIFO-buffered UART transmitter
module tb_fnc_uart_txp;

   localparam int OSR = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        uart_en;
   logic [31:0] refclk_st;
   logic [3:0]  cfg_dbits;
   logic [1:0]  cfg_parity;
   logic        cfg_stop2;
   logic        wr_en;
   logic [7:0]  wr_data;
   logic        fifo_full;
   logic [4:0]  fifo_level;
   logic        ovf_err;
   logic        err_clr;
   logic        tx_busy;
   logic        txd;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_w[$];
   int cap[$];

   fnc_uart_txp #(
      .DW         (8),
      .FIFO_DEPTH (16),
      .OSR        (OSR),
      .CNT_W      (32)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .uart_en    (uart_en),
      .refclk_st  (refclk_st),
      .cfg_dbits  (cfg_dbits),
      .cfg_parity (cfg_parity),
      .cfg_stop2  (cfg_stop2),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .fifo_full  (fifo_full),
      .fifo_level (fifo_level),
      .ovf_err    (ovf_err),
      .err_clr    (err_clr),
      .tx_busy    (tx_busy),
      .txd        (txd)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [3:0] dbits;
      logic [1:0] par;
      logic       stop2;
      int         rs;
      logic [7:0] data;
      int         exp_db;
      int         exp_bits;
      int         exp_par;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference waveform: one entry per clock, built from the frame rules directly.
   task automatic model_append(input int dbits_raw, input int par, input int stop2,
                               input int rs, input int data);
      int db = (dbits_raw < 5) ? 5 : ((dbits_raw > 8) ? 8 : dbits_raw);
      int t  = OSR * (rs + 1);
      int ones = 0;
      int bits[$];
      bits.push_back(0);
      for (int i = 0; i < db; i++) begin
         bits.push_back((data >> i) & 1);
         ones += (data >> i) & 1;
      end
      if (par == 1) bits.push_back(ones % 2);
      if (par == 2) bits.push_back(1 - (ones % 2));
      bits.push_back(1);
      if (stop2 != 0) bits.push_back(1);
      foreach (bits[k]) for (int j = 0; j < t; j++) exp_w.push_back(bits[k]);
   endtask

   task automatic set_cfg(input logic [3:0] db, input logic [1:0] par, input logic s2, input int rs);
      cfg_dbits  = db;
      cfg_parity = par;
      cfg_stop2  = s2;
      refclk_st  = 32'(rs);
   endtask

   task automatic push_byte(input logic [7:0] d);
      @(posedge clk); #1;
      wr_en   = 1'b1;
      wr_data = d;
      @(posedge clk); #1;
      wr_en   = 1'b0;
   endtask

   // Cycle 0 is the cycle in which the write is driven; capture ends when tx_busy falls.
   task automatic capture(input bit scramble, output int lat);
      lat = -1;
      cap.delete();
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if (tx_busy) begin
            lat = c;
            break;
         end
      end
      if (lat >= 0) begin
         if (scramble) begin
            cfg_dbits  = 4'($urandom_range(0, 15));
            cfg_parity = 2'($urandom_range(0, 3));
            cfg_stop2  = 1'($urandom_range(0, 1));
         end
         while (tx_busy && cap.size() < 8000) begin
            cap.push_back(int'(txd));
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input bit scramble, output int lat);
      int l;
      fork
         push_byte(d);
         capture(scramble, l);
      join
      lat = l;
   endtask

   task automatic check_wave(input string tag);
      int bad = 0;
      int n = (cap.size() < exp_w.size()) ? cap.size() : exp_w.size();
      for (int i = 0; i < n; i++) if (cap[i] != exp_w[i]) bad++;
      check({tag, "_len"}, cap.size(), exp_w.size());
      check({tag, "_wave_bad_bits"}, bad, 0);
      check({tag, "_idle_txd"}, int'(txd), 1);
   endtask

   initial begin
      int lat;
      int t;
      logic [7:0] bq[17];

      rst = 1'b1; uart_en = 1'b1; wr_en = 1'b0; wr_data = '0; err_clr = 1'b0;
      set_cfg(4'd8, 2'b00, 1'b0, 0);

      vecs[0] = '{4'd8,  2'b00, 1'b0, 0, 8'h55, 8, 10, -1};
      vecs[1] = '{4'd7,  2'b01, 1'b1, 3, 8'h83, 7, 11,  0};
      vecs[2] = '{4'd5,  2'b10, 1'b0, 0, 8'h1F, 5,  8,  0};
      vecs[3] = '{4'd2,  2'b01, 1'b0, 1, 8'h07, 5,  8,  1};
      vecs[4] = '{4'd15, 2'b10, 1'b1, 0, 8'hF0, 8, 12,  1};

      repeat (3) @(posedge clk);
      #1;
      check("rst_txd", int'(txd), 1);
      check("rst_busy", int'(tx_busy), 0);
      check("rst_level", int'(fifo_level), 0);
      check("rst_full", int'(fifo_full), 0);
      check("rst_ovf", int'(ovf_err), 0);
      rst = 1'b0;

      foreach (vecs[v]) begin
         set_cfg(vecs[v].dbits, vecs[v].par, vecs[v].stop2, vecs[v].rs);
         t = OSR * (vecs[v].rs + 1);
         exp_w.delete();
         model_append(int'(vecs[v].dbits), int'(vecs[v].par), int'(vecs[v].stop2),
                      vecs[v].rs, int'(vecs[v].data));
         send_frame(vecs[v].data, 1'b0, lat);
         check($sformatf("vec%0d_latency", v), lat, 2);
         check($sformatf("vec%0d_busy_cycles", v), cap.size(), vecs[v].exp_bits * t);
         if (vecs[v].exp_par >= 0 && cap.size() > (1 + vecs[v].exp_db) * t + t / 2)
            check($sformatf("vec%0d_parity", v), cap[(1 + vecs[v].exp_db) * t + t / 2],
                  vecs[v].exp_par);
         check_wave($sformatf("vec%0d", v));
      end

      for (int r = 0; r < 6; r++) begin
         logic [3:0] db = 4'($urandom_range(0, 15));
         logic [1:0] pr = 2'($urandom_range(0, 3));
         logic       s2 = 1'($urandom_range(0, 1));
         int         rs = $urandom_range(0, 2);
         logic [7:0] d  = 8'($urandom);
         set_cfg(db, pr, s2, rs);
         exp_w.delete();
         model_append(int'(db), int'(pr), int'(s2), rs, int'(d));
         send_frame(d, 1'b1, lat);
         check($sformatf("rnd%0d_latency", r), lat, 2);
         check_wave($sformatf("rnd%0d", r));
      end

      // 17 back-to-back writes, then an overflowing write with a simultaneous clear.
      set_cfg(4'd8, 2'b00, 1'b0, 0);
      exp_w.delete();
      foreach (bq[i]) begin
         bq[i] = 8'($urandom);
         model_append(8, 0, 0, 0, int'(bq[i]));
      end
      fork
         begin
            for (int i = 0; i < 17; i++) begin
               @(posedge clk); #1;
               if (i == 16) begin
                  check("b2b_level_before_last", int'(fifo_level), 15);
                  check("b2b_full_before_last", int'(fifo_full), 0);
               end
               wr_en   = 1'b1;
               wr_data = bq[i];
            end
            @(posedge clk); #1;
            check("b2b_full", int'(fifo_full), 1);
            check("b2b_level16", int'(fifo_level), 16);
            wr_data = 8'hEE;
            err_clr = 1'b1;
            @(posedge clk); #1;
            wr_en   = 1'b0;
            err_clr = 1'b0;
            check("ovf_set_wins", int'(ovf_err), 1);
            check("ovf_level_kept", int'(fifo_level), 16);
            @(posedge clk); #1;
            err_clr = 1'b1;
            @(posedge clk); #1;
            err_clr = 1'b0;
            check("ovf_cleared", int'(ovf_err), 0);
         end
         capture(1'b0, lat);
      join
      check("b2b_latency", lat, 2);
      check_wave("b2b");

      // uart_en dropped mid-DATA with another byte queued.
      set_cfg(4'd8, 2'b00, 1'b0, 0);
      push_byte(8'h3C);
      push_byte(8'h11);
      repeat (40) @(posedge clk);
      #1;
      check("en_pre_busy", int'(tx_busy), 1);
      check("en_pre_level", int'(fifo_level), 1);
      uart_en = 1'b0;
      @(posedge clk); #1;
      check("en_off_txd", int'(txd), 1);
      check("en_off_busy", int'(tx_busy), 0);
      check("en_off_level", int'(fifo_level), 0);
      uart_en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("en_back_idle", int'(tx_busy), 0);
      exp_w.delete();
      model_append(8, 0, 0, 0, 'hA5);
      send_frame(8'hA5, 1'b0, lat);
      check("a5_latency", lat, 2);
      check_wave("a5");

      // ovf survives uart_en; rst mid-frame clears everything.
      for (int i = 0; i < 18; i++) begin
         @(posedge clk); #1;
         wr_en   = 1'b1;
         wr_data = 8'(i);
      end
      @(posedge clk); #1;
      wr_en = 1'b0;
      check("fill_ovf", int'(ovf_err), 1);
      check("fill_full", int'(fifo_full), 1);
      uart_en = 1'b0;
      @(posedge clk); #1;
      check("dis_level", int'(fifo_level), 0);
      check("dis_ovf_kept", int'(ovf_err), 1);
      uart_en = 1'b1;
      push_byte(8'h5A);
      repeat (40) @(posedge clk);
      #1;
      check("rst_pre_busy", int'(tx_busy), 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_txd", int'(txd), 1);
      check("midrst_busy", int'(tx_busy), 0);
      check("midrst_level", int'(fifo_level), 0);
      check("midrst_full", int'(fifo_full), 0);
      check("midrst_ovf", int'(ovf_err), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fnc_uart_txp.md
# fnc_uart_txp

Parametrised UART transmitter for the RockWave peripheral bus; next generation of the fixed 8N1 transmitter. Adds a write FIFO, runtime-selectable frame format (5–8 data bits, none/even/odd parity, 1 or 2 stop bits), deterministic start-bit timing and overflow reporting. Sits between the register-interface block, which drives configuration and data writes, and the TXD pad.

## Interface
- `DW`, 8: maximum data bits; the frame width is selected at runtime from 5 to DW.
- `FIFO_DEPTH`, 16: number of TX FIFO entries; must be a power of two and at least 2.
- `OSR`, 16: prescaler ticks per bit.
- `CNT_W`, 32: prescaler width.
- `clk`  in  1  global clock; single clock domain.
- `rst`  in  1  synchronous reset, active-high.
- `uart_en`  in  1  block enable; low = flush and hold idle.
- `refclk_st`  in  CNT_W  tick period minus 1, in clk cycles.
- `cfg_dbits`  in  4  data bits; values below 5 clamp to 5, values above DW clamp to DW.
- `cfg_parity`  in  2  00 = none, 01 = even, 10 = odd, 11 = none.
- `cfg_stop2`  in  1  0 = one stop bit, 1 = two stop bits.
- `wr_en`  in  1  push `wr_data` into the FIFO.
- `wr_data`  in  DW  byte to send, LSB first; bits at or above `cfg_dbits` are ignored.
- `fifo_full`  out  1  FIFO full, from the registered count.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- `ovf_err`  out  1  sticky: a write was dropped.
- `err_clr`  in  1  clears `ovf_err`.
- `tx_busy`  out  1  a frame is in progress.
- `txd`  out  1  serial output, registered; idles high.

## Operation
- Reset or `uart_en` = 0:
  - `txd` = 1, `tx_busy` = 0.
  - FIFO flushed, so `fifo_level` = 0 and `fifo_full` = 0.
  - FSM goes to IDLE and the prescaler reloads.
  - `ovf_err` is cleared by reset only; `uart_en` does not clear it.
- Prescaler:
  - Down-counter loaded with `refclk_st`; a tick fires when it reaches 0, and the counter then reloads.
  - The prescaler and the bit counter restart at each frame start, so every bit, the start bit included, lasts exactly OSR·(refclk_st+1) clocks.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when the FIFO is not empty. The FIFO pops in this cycle, and `cfg_*` plus the popped word are latched for the whole frame.
  - START → DATA after one bit time.
  - DATA shifts out the latched word LSB first. After `cfg_dbits` bits it goes to PARITY if parity is enabled, otherwise to STOP.
  - PARITY sends one bit: the XOR of the data bits for even parity, its inverse for odd parity.
  - STOP holds `txd` high for 1 or 2 bit times. It then goes to START with a pop in the same cycle if the FIFO is not empty (back-to-back, no idle gap), else to IDLE.
- FIFO:
  - A write is accepted when `wr_en` = 1 and `fifo_full` = 0.
  - A write while full is dropped and sets `ovf_err`, even if a pop occurs in the same cycle.
  - Simultaneous write and pop on a non-full FIFO leaves the level unchanged.
- `err_clr` and an overflow in the same cycle leave `ovf_err` = 1 (set wins).
- `cfg_*` changes during a frame take effect at the next frame.

## Timing
- Write into an empty FIFO while idle:
  - Cycle 0: `wr_en` asserted.
  - Cycle 1: FIFO not empty, pop.
  - Cycle 2: `txd` = 0 and `tx_busy` = 1.
- Frame length = (1 + dbits + parity + stop) · OSR·(refclk_st+1) clocks.
- `tx_busy` falls in the first cycle after the last stop bit if the FIFO is empty. If the FIFO is not empty it stays high across frames.
- `fifo_level` and `fifo_full` update one cycle after a push or pop.
- `uart_en` falling mid-frame: `txd` = 1 on the next cycle and the frame is aborted. Same behaviour for `rst`.
- `refclk_st` = 0 gives one tick per clk cycle.

## Structure
- Package `fnc_uart_pkg` holds:
  - the FSM state encoding;
  - the parity codes `PAR_NONE`, `PAR_EVEN`, `PAR_ODD`;
  - `DBITS_MIN` = 5.
- Sub-module `fnc_uart_fifo`: synchronous FIFO with `push`, `pop`, `din`, `dout`, `level`, `full`, `empty` and `flush`, parametrised by width and depth.
- The prescaler, bit counter, FSM and shift register are implemented inline.

## Test plan
- OSR=16, refclk_st=0, 8N1, write 0x55:
  - `txd` goes low at cycle 2.
  - Then the bits 1,0,1,0,1,0,1,0 follow, then the stop bit; each bit lasts 16 clocks.
  - `tx_busy` is high for 160 cycles.
- refclk_st=3, 7 data bits, even parity, 2 stop bits, write 0x83:
  - Data sent is 1100000.
  - Parity bit = 0.
  - Bits are 64 clocks wide; frame = 11 bits = 704 clocks.
- Odd parity, 5 data bits, write 0x1F:
  - Data bits are 11111.
  - Parity bit = 0.
- Write 17 bytes back-to-back with FIFO_DEPTH=16 while idle:
  - The first byte pops at once, so all 17 are accepted and `fifo_full` rises after the 17th.
  - An 18th write is dropped and `ovf_err` = 1.
  - `err_clr` clears `ovf_err`.
  - The frames are transmitted with no idle gaps.
- Drop `uart_en` in the middle of DATA:
  - Next cycle: `txd` = 1, `tx_busy` = 0, `fifo_level` = 0.
  - Re-enable and write 0xA5: a clean frame is sent.
- Assert `rst` mid-frame: all outputs return to their reset values on the next cycle.
